// File: rtl/cordic_form_scheduler.sv
// Form-descriptor scheduler for the CORDIC pipeline: issues one token per
// descriptor slot for every accepted pixel and rotates form angles per frame.
module cordic_form_scheduler #(
    parameter int NUM_FORMS = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_enable,
    input  logic             cfg_form,
    input  logic [8:0]       cfg_color,
    input  logic [8:0]       cfg_ref_x,
    input  logic [8:0]       cfg_ref_y,
    input  logic [6:0]       cfg_size,
    input  logic [8:0]       cfg_angle,
    input  logic [3:0]       cfg_rot_step,
    input  logic             frame_tick,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    output logic             nst1_bubble,
    output logic [8:0]       nst1_color,
    output logic [9:0]       nst1_pixel_x,
    output logic [9:0]       nst1_pixel_y,
    output logic [8:0]       nst1_ref_point_x,
    output logic [8:0]       nst1_ref_point_y,
    output logic             nst1_form,
    output logic [6:0]       size,
    output logic [8:0]       nst1_angle,
    output logic             nst1_last,
    output logic [IDX_W-1:0] nst1_slot
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ROT   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_FORMS - 1);

    state_t           state;
    logic [IDX_W-1:0] slot;
    logic             rot_pending;
    logic [9:0]       cur_x;
    logic [9:0]       cur_y;
    logic             accept;

    logic             tbl_en    [NUM_FORMS];
    logic             tbl_form  [NUM_FORMS];
    logic [8:0]       tbl_color [NUM_FORMS];
    logic [8:0]       tbl_ref_x [NUM_FORMS];
    logic [8:0]       tbl_ref_y [NUM_FORMS];
    logic [6:0]       tbl_size  [NUM_FORMS];
    logic [8:0]       tbl_angle [NUM_FORMS];
    logic [3:0]       tbl_step  [NUM_FORMS];

    // Angle plus signed step, wrapped back into -180..179.
    function automatic logic [8:0] rotate(input logic [8:0] a, input logic [3:0] s);
        logic signed [9:0] t;
        t = $signed({a[8], a}) + $signed({{6{s[3]}}, s});
        if (t > 10'sd179)
            t = t - 10'sd360;
        else if (t < -10'sd180)
            t = t + 10'sd360;
        return t[8:0];
    endfunction

    assign pix_ready = !rot_pending &&
                       ((state == IDLE) || ((state == ISSUE) && (slot == LAST_SLOT)));
    assign accept    = pix_valid && pix_ready;

    // A config write to a slot overrides that slot's rotation in the ROT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_FORMS; i++) begin
                tbl_en[i]    <= 1'b0;
                tbl_form[i]  <= 1'b0;
                tbl_color[i] <= '0;
                tbl_ref_x[i] <= '0;
                tbl_ref_y[i] <= '0;
                tbl_size[i]  <= '0;
                tbl_angle[i] <= '0;
                tbl_step[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_FORMS; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    tbl_en[i]    <= cfg_enable;
                    tbl_form[i]  <= cfg_form;
                    tbl_color[i] <= cfg_color;
                    tbl_ref_x[i] <= cfg_ref_x;
                    tbl_ref_y[i] <= cfg_ref_y;
                    tbl_size[i]  <= cfg_size;
                    tbl_angle[i] <= cfg_angle;
                    tbl_step[i]  <= cfg_rot_step;
                end else if ((state == ROT) && tbl_en[i]) begin
                    tbl_angle[i] <= rotate(tbl_angle[i], tbl_step[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            slot             <= '0;
            rot_pending      <= 1'b0;
            cur_x            <= '0;
            cur_y            <= '0;
            nst1_bubble      <= 1'b1;
            nst1_color       <= '0;
            nst1_pixel_x     <= '0;
            nst1_pixel_y     <= '0;
            nst1_ref_point_x <= '0;
            nst1_ref_point_y <= '0;
            nst1_form        <= 1'b0;
            size             <= '0;
            nst1_angle       <= '0;
            nst1_last        <= 1'b0;
            nst1_slot        <= '0;
        end else begin
            // The ROT cycle consumes the pending request; a tick in that same
            // cycle re-arms it for another rotation.
            if (state == ROT)
                rot_pending <= frame_tick;
            else if (frame_tick)
                rot_pending <= 1'b1;

            unique case (state)
                IDLE: begin
                    nst1_bubble <= 1'b1;
                    nst1_last   <= 1'b0;
                    if (rot_pending) begin
                        state <= ROT;
                    end else if (pix_valid) begin
                        state <= ISSUE;
                        slot  <= '0;
                        cur_x <= pix_x;
                        cur_y <= pix_y;
                    end
                end
                ISSUE: begin
                    nst1_bubble      <= !tbl_en[slot];
                    nst1_color       <= tbl_color[slot];
                    nst1_pixel_x     <= cur_x;
                    nst1_pixel_y     <= cur_y;
                    nst1_ref_point_x <= tbl_ref_x[slot];
                    nst1_ref_point_y <= tbl_ref_y[slot];
                    nst1_form        <= tbl_form[slot];
                    size             <= tbl_size[slot];
                    nst1_angle       <= tbl_angle[slot];
                    nst1_last        <= (slot == LAST_SLOT);
                    nst1_slot        <= slot;
                    if (slot == LAST_SLOT) begin
                        if (accept) begin
                            slot  <= '0;
                            cur_x <= pix_x;
                            cur_y <= pix_y;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                ROT: begin
                    nst1_bubble <= 1'b1;
                    nst1_last   <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_form_scheduler.sv
// Randomized self-checking bench for cordic_form_scheduler against a
// transaction-level descriptor table model.
module tb_cordic_form_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic          cfg_enable;
    logic          cfg_form;
    logic [8:0]    cfg_color;
    logic [8:0]    cfg_ref_x;
    logic [8:0]    cfg_ref_y;
    logic [6:0]    cfg_size;
    logic [8:0]    cfg_angle;
    logic [3:0]    cfg_rot_step;
    logic          frame_tick;
    logic          pix_valid;
    logic          pix_ready;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic          nst1_bubble;
    logic [8:0]    nst1_color;
    logic [9:0]    nst1_pixel_x;
    logic [9:0]    nst1_pixel_y;
    logic [8:0]    nst1_ref_point_x;
    logic [8:0]    nst1_ref_point_y;
    logic          nst1_form;
    logic [6:0]    size;
    logic [8:0]    nst1_angle;
    logic          nst1_last;
    logic [IW-1:0] nst1_slot;

    int n_checks = 0;
    int n_fail   = 0;

    int m_en[N], m_form[N], m_color[N], m_rx[N], m_ry[N], m_size[N], m_ang[N], m_step[N];

    cordic_form_scheduler #(.NUM_FORMS(N), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_enable(cfg_enable), .cfg_form(cfg_form),
        .cfg_color(cfg_color), .cfg_ref_x(cfg_ref_x), .cfg_ref_y(cfg_ref_y),
        .cfg_size(cfg_size), .cfg_angle(cfg_angle), .cfg_rot_step(cfg_rot_step),
        .frame_tick(frame_tick), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y),
        .nst1_bubble(nst1_bubble), .nst1_color(nst1_color),
        .nst1_pixel_x(nst1_pixel_x), .nst1_pixel_y(nst1_pixel_y),
        .nst1_ref_point_x(nst1_ref_point_x), .nst1_ref_point_y(nst1_ref_point_y),
        .nst1_form(nst1_form), .size(size), .nst1_angle(nst1_angle),
        .nst1_last(nst1_last), .nst1_slot(nst1_slot)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap(input int a);
        return ((a + 180) % 360 + 360) % 360 - 180;
    endfunction

    function automatic int rnd_step();
        return int'($urandom_range(0, 15)) - 8;
    endfunction

    function automatic int rnd_angle();
        return int'($urandom_range(0, 359)) - 180;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_form[i] = 0; m_color[i] = 0; m_rx[i] = 0;
            m_ry[i] = 0; m_size[i] = 0; m_ang[i] = 0; m_step[i] = 0;
        end
    endtask

    // Drives a config write for the coming edge and records it in the model.
    task automatic drive_cfg(input int idx, input int en, input int ang, input int st);
        int c, x, y, s, f;
        c = int'($urandom_range(0, 511));
        x = int'($urandom_range(0, 511));
        y = int'($urandom_range(0, 511));
        s = int'($urandom_range(0, 127));
        f = int'($urandom_range(0, 1));
        cfg_we = 1'b1;          cfg_idx = idx[IW-1:0];
        cfg_enable = en[0];     cfg_form = f[0];
        cfg_color = c[8:0];     cfg_ref_x = x[8:0];     cfg_ref_y = y[8:0];
        cfg_size = s[6:0];      cfg_angle = ang[8:0];   cfg_rot_step = st[3:0];
        m_en[idx] = en; m_form[idx] = f; m_color[idx] = c; m_rx[idx] = x;
        m_ry[idx] = y; m_size[idx] = s; m_ang[idx] = ang; m_step[idx] = st;
    endtask

    task automatic write_slot(input int idx, input int en, input int ang, input int st);
        drive_cfg(idx, en, ang, st);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic check_token(input int p, input int s, input int ex, input int ey);
        logic [8:0] ea;
        ea = m_ang[s][8:0];
        check($sformatf("p%0d_s%0d_bubble", p, s), nst1_bubble, (m_en[s] == 0));
        check($sformatf("p%0d_s%0d_slot", p, s), nst1_slot, s);
        check($sformatf("p%0d_s%0d_last", p, s), nst1_last, (s == N - 1));
        check($sformatf("p%0d_s%0d_px", p, s), nst1_pixel_x, ex);
        check($sformatf("p%0d_s%0d_py", p, s), nst1_pixel_y, ey);
        if (m_en[s] != 0) begin
            check($sformatf("p%0d_s%0d_color", p, s), nst1_color, m_color[s]);
            check($sformatf("p%0d_s%0d_refx", p, s), nst1_ref_point_x, m_rx[s]);
            check($sformatf("p%0d_s%0d_refy", p, s), nst1_ref_point_y, m_ry[s]);
            check($sformatf("p%0d_s%0d_form", p, s), nst1_form, m_form[s]);
            check($sformatf("p%0d_s%0d_size", p, s), size, m_size[s]);
            check($sformatf("p%0d_s%0d_angle", p, s), nst1_angle, ea);
        end
    endtask

    // Sends n back-to-back pixels from IDLE. tick_slot>=0 pulses frame_tick
    // during that slot of the first pixel (only used with n==1).
    task automatic run_pixels(input int n, input int tick_slot, input int fx, input int fy);
        int xs[8], ys[8];
        int rx, ry;
        bit exp_ready;
        for (int p = 0; p < n; p++) begin
            xs[p] = int'($urandom_range(0, 1023));
            ys[p] = int'($urandom_range(0, 1023));
        end
        if (fx >= 0) begin
            xs[0] = fx;
            ys[0] = fy;
        end
        pix_valid = 1'b1;
        pix_x = xs[0][9:0];
        pix_y = ys[0][9:0];
        check("ready_idle", pix_ready, 1);
        step();
        for (int p = 0; p < n; p++) begin
            for (int s = 0; s < N; s++) begin
                exp_ready = (s == N - 1) && !(tick_slot >= 0 && tick_slot < N - 1);
                check($sformatf("p%0d_s%0d_ready", p, s), pix_ready, exp_ready);
                frame_tick = (p == 0 && s == tick_slot);
                if (s == N - 1) begin
                    if (p + 1 < n) begin
                        pix_x = xs[p+1][9:0];
                        pix_y = ys[p+1][9:0];
                    end else begin
                        pix_valid = 1'b0;
                    end
                end else begin
                    rx = int'($urandom_range(0, 1023));
                    ry = int'($urandom_range(0, 1023));
                    pix_x = rx[9:0];
                    pix_y = ry[9:0];
                end
                step();
                frame_tick = 1'b0;
                check_token(p, s, xs[p], ys[p]);
            end
        end
        if (tick_slot < 0) begin
            step();
            check("after_group_bubble", nst1_bubble, 1);
            check("after_group_last", nst1_last, 0);
            check("after_group_ready", pix_ready, 1);
        end
    endtask

    // Entered in the IDLE cycle with a rotation pending. extra=1 adds a tick
    // that must be absorbed; extra=2 adds a tick in the ROT cycle itself.
    task automatic finish_rotation(input int coll, input int cang, input int cstep, input int extra);
        check("pend_ready", pix_ready, 0);
        frame_tick = (extra == 1);
        step();
        frame_tick = (extra == 2);
        check("rot_ready", pix_ready, 0);
        check("rot_bubble", nst1_bubble, 1);
        for (int i = 0; i < N; i++)
            if (m_en[i] != 0) m_ang[i] = wrap(m_ang[i] + m_step[i]);
        if (coll >= 0) drive_cfg(coll, 1, cang, cstep);
        step();
        cfg_we = 1'b0;
        frame_tick = 1'b0;
        check("post_rot_ready", pix_ready, (extra == 2) ? 0 : 1);
        check("post_rot_bubble", nst1_bubble, 1);
        check("post_rot_last", nst1_last, 0);
    endtask

    task automatic frame_rotation(input int coll, input int cang, input int cstep, input int extra);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        finish_rotation(coll, cang, cstep, extra);
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_enable = 1'b0; cfg_form = 1'b0;
        cfg_color = '0; cfg_ref_x = '0; cfg_ref_y = '0; cfg_size = '0; cfg_angle = '0;
        cfg_rot_step = '0; frame_tick = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        clear_model();
        repeat (2) step();
        check("rst_bubble", nst1_bubble, 1);
        check("rst_last", nst1_last, 0);
        check("rst_slot", nst1_slot, 0);
        check("rst_angle", nst1_angle, 0);
        check("rst_color", nst1_color, 0);
        check("rst_pixel_x", nst1_pixel_x, 0);
        check("rst_ready", pix_ready, 1);
        reset = 1'b1;
        step();

        // Single pixel with every slot enabled
        for (int i = 0; i < N; i++) write_slot(i, 1, rnd_angle(), rnd_step());
        run_pixels(1, -1, 12, 34);

        // Slot 2 disabled, three back-to-back pixels
        write_slot(2, 0, rnd_angle(), rnd_step());
        run_pixels(3, -1, -1, -1);

        // Wrap-around boundaries and a zero step
        write_slot(0, 1, 178, 3);
        write_slot(1, 1, -179, -4);
        write_slot(2, 1, 45, 0);
        write_slot(3, 1, rnd_angle(), rnd_step());
        frame_rotation(-1, 0, 0, 0);
        run_pixels(1, -1, -1, -1);

        // Tick during a group is deferred until the group ends
        run_pixels(1, 1, -1, -1);
        finish_rotation(-1, 0, 0, 0);
        run_pixels(1, -1, -1, -1);

        // Config write to slot 1 collides with the ROT cycle
        for (int i = 0; i < N; i++) write_slot(i, 1, rnd_angle(), rnd_step());
        frame_rotation(1, 90, 5, 0);
        run_pixels(1, -1, -1, -1);

        // Second tick while pending is absorbed; tick in ROT re-arms
        frame_rotation(-1, 0, 0, 1);
        run_pixels(1, -1, -1, -1);
        frame_rotation(-1, 0, 0, 2);
        finish_rotation(-1, 0, 0, 0);
        run_pixels(1, -1, -1, -1);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1)
                    write_slot(i, int'($urandom_range(0, 3) != 0), rnd_angle(), rnd_step());
            for (int k = int'($urandom_range(0, 2)); k > 0; k--)
                frame_rotation(-1, 0, 0, 0);
            run_pixels(int'($urandom_range(1, 4)), -1, -1, -1);
        end

        // Reset while the slot-1 token is being processed
        for (int i = 0; i < N; i++) write_slot(i, 1, rnd_angle(), rnd_step());
        pix_valid = 1'b1;
        pix_x = 10'd100;
        pix_y = 10'd200;
        step();
        pix_valid = 1'b0;
        step();
        check("pre_rst_bubble", nst1_bubble, 0);
        check("pre_rst_slot", nst1_slot, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_bubble", nst1_bubble, 1);
        check("mid_rst_last", nst1_last, 0);
        check("mid_rst_slot", nst1_slot, 0);
        step();
        reset = 1'b1;
        clear_model();
        step();
        check("rel_ready", pix_ready, 1);
        check("rel_bubble", nst1_bubble, 1);
        step();
        check("no_tail_bubble", nst1_bubble, 1);
        check("no_tail_last", nst1_last, 0);
        run_pixels(1, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
